// File: rtl/cnn_pkg.sv
// Shared types and constants for the convolution compute stage.
package cnn_pkg;

  localparam int DATA_W      = 16;
  localparam int ACC_W       = 40;
  localparam int K           = 5;
  localparam int TAPS        = K * K;
  localparam int MAX_BLK     = 32;
  localparam int BLOCK_WORDS = MAX_BLK * MAX_BLK;
  localparam int FRAC        = 8;

  typedef logic signed [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/conv_window_mac_mac_unit.sv
// Signed MAC with clear/enable and a Q8.8 shift-and-saturate output.
// CONV_RELU_EN: when defined, negative saturated results are forced to zero.
module mac_unit
  import cnn_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  word_t             a,
  input  word_t             b,
  output logic [DATA_W-1:0] sat_out
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(2 ** (DATA_W - 1));

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          sat;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    shifted = acc_q >>> FRAC;
    if (shifted > SAT_MAX) begin
      sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat = shifted[DATA_W-1:0];
    end
`ifdef CONV_RELU_EN
    sat_out = sat[DATA_W-1] ? '0 : sat;
`else
    sat_out = sat;
`endif
  end

endmodule

// File: rtl/conv_window_mac.sv
// Valid 5x5 convolution over a square block, one MAC per cycle, one pixel streamed per 26 cycles.
// Optional build macro CONV_RELU_EN (handled in mac_unit) clamps negative pixels to zero.
module conv_window_mac
  import cnn_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       size,
  input  logic [DATA_W-1:0] filter [TAPS],
  input  logic [DATA_W-1:0] block  [BLOCK_WORDS],
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       out_row,
  output logic [15:0]       out_col,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for enable; captures size and filter
  // MAC   | accumulating one tap per cycle for the current window
  // EMIT  | strobing the saturated pixel and advancing the window
  // DONE  | one-cycle done pulse, busy drops

  localparam logic [15:0] K16 = 16'(K);
  localparam logic [15:0] MAX16 = 16'(MAX_BLK);

  state_t            state_q, state_d;
  logic [15:0]       size_q, size_d;
  logic [DATA_W-1:0] filter_q [TAPS];
  logic [DATA_W-1:0] filter_d [TAPS];
  logic [15:0]       row_q, row_d, col_q, col_d;
  logic [2:0]        kr_q, kr_d, kc_q, kc_d;
  logic              busy_q, busy_d, out_valid_q, out_valid_d, done_q, done_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [15:0]       out_row_q, out_row_d, out_col_q, out_col_d;

  logic              acc_clr, acc_en;
  logic [15:0]       idx, lim;
  logic [4:0]        tap_idx;
  logic [DATA_W-1:0] blk_word, pix;

  always_comb begin
    lim      = size_q - K16;
    tap_idx  = 5'(kr_q) * 5'(K) + 5'(kc_q);
    idx      = (row_q + 16'(kr_q)) * size_q + col_q + 16'(kc_q);
    blk_word = (idx < 16'(BLOCK_WORDS)) ? block[idx[9:0]] : '0;
  end

  mac_unit #(.ACC_W(ACC_W)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clr     (acc_clr),
    .en      (acc_en),
    .a       (blk_word),
    .b       (filter_q[tap_idx]),
    .sat_out (pix)
  );

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    filter_d    = filter_q;
    row_d       = row_q;
    col_d       = col_q;
    kr_d        = kr_q;
    kc_d        = kc_q;
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    done_d      = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          size_d   = size;
          filter_d = filter;
          busy_d   = 1'b1;
          row_d    = '0;
          col_d    = '0;
          kr_d     = '0;
          kc_d     = '0;
          acc_clr  = 1'b1;
          state_d  = (size < K16 || size > MAX16) ? DONE : MAC;
        end
      end
      MAC: begin
        acc_en = 1'b1;
        if (kc_q == 3'(K - 1)) begin
          kc_d = '0;
          if (kr_q == 3'(K - 1)) begin
            kr_d    = '0;
            state_d = EMIT;
          end else begin
            kr_d = kr_q + 3'd1;
          end
        end else begin
          kc_d = kc_q + 3'd1;
        end
      end
      EMIT: begin
        out_valid_d = 1'b1;
        out_data_d  = pix;
        out_row_d   = row_q;
        out_col_d   = col_q;
        acc_clr     = 1'b1;
        state_d     = MAC;
        if (col_q == lim) begin
          col_d = '0;
          if (row_q == lim) begin
            state_d = DONE;
          end else begin
            row_d = row_q + 16'd1;
          end
        end else begin
          col_d = col_q + 16'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= '0;
      filter_q    <= '{default: '0};
      row_q       <= '0;
      col_q       <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      filter_q    <= filter_d;
      row_q       <= row_d;
      col_q       <= col_d;
      kr_q        <= kr_d;
      kc_q        <= kc_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac; cycle numbers count from the cycle enable is presented.
module tb_conv_window_mac;
  import cnn_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] size = '0;
  logic [15:0] filter [TAPS];
  logic [15:0] block  [BLOCK_WORDS];
  logic        busy, out_valid, done;
  logic [15:0] out_data, out_row, out_col;

  int total = 0;
  int bad = 0;

  logic [15:0] q_data [$];
  logic [15:0] q_row  [$];
  logic [15:0] q_col  [$];
  int          q_cyc  [$];

  always #5 clk = ~clk;

  conv_window_mac dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .size      (size),
    .filter    (filter),
    .block     (block),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_block_const(input logic [15:0] v);
    for (int i = 0; i < BLOCK_WORDS; i++) block[i] = v;
  endtask

  task automatic fill_block_ramp();
    for (int i = 0; i < BLOCK_WORDS; i++) block[i] = 16'((i % 64) << 8);
  endtask

  task automatic fill_filt_const(input logic [15:0] v);
    for (int i = 0; i < TAPS; i++) filter[i] = v;
  endtask

  task automatic fill_filt_identity();
    for (int i = 0; i < TAPS; i++) filter[i] = (i == 12) ? 16'h0100 : 16'h0000;
  endtask

  // mode: 0 = pulse enable, 1 = toggle enable while busy, 2 = hold enable high
  task automatic run_pass(input int n, input int budget, input int mode, output int done_cyc);
    q_data.delete(); q_row.delete(); q_col.delete(); q_cyc.delete();
    done_cyc = -1;
    @(negedge clk);
    size   = 16'(n);
    enable = 1'b1;
    @(posedge clk); #1;
    if (mode != 2) enable = 1'b0;
    chk("busy_at_start", busy, 1);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (out_valid) begin
        q_data.push_back(out_data);
        q_row.push_back(out_row);
        q_col.push_back(out_col);
        q_cyc.push_back(cyc);
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mode == 1) enable = (cyc < 200) ? cyc[2] : 1'b0;
      @(posedge clk); #1;
    end
    if (mode != 2) enable = 1'b0;
  endtask

  task automatic watch_idle(input int cycles, output int n_valid, output int n_done);
    n_valid = 0;
    n_done  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) n_valid++;
      if (done) n_done++;
    end
  endtask

  initial begin
    int dc, nv, nd, cnt;
    fill_block_const(16'h0000);
    fill_filt_const(16'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", done, 0);
    @(negedge clk); reset = 1'b0;

    // N=5 all ones: single 25.0 pixel
    fill_block_const(16'h0100);
    fill_filt_const(16'h0100);
    run_pass(5, 100, 0, dc);
    chk("n5_done_cyc", dc, 28);
    chk("n5_strobes", q_data.size(), 1);
    if (q_data.size() >= 1) begin
      chk("n5_data", q_data[0], 16'h1900);
      chk("n5_row", q_row[0], 0);
      chk("n5_col", q_col[0], 0);
      chk("n5_strobe_cyc", q_cyc[0], 27);
    end
    chk("n5_busy_at_done", busy, 0);
    watch_idle(5, nv, nd);
    chk("n5_hold_data", out_data, 16'h1900);
    chk("n5_idle_strobes", nv, 0);

    // N=6 ramp with identity filter
    fill_block_ramp();
    fill_filt_identity();
    run_pass(6, 200, 0, dc);
    chk("n6_done_cyc", dc, 4 * 26 + 2);
    chk("n6_strobes", q_data.size(), 4);
    if (q_data.size() == 4) begin
      chk("n6_d0", q_data[0], 16'h0E00);
      chk("n6_d1", q_data[1], 16'h0F00);
      chk("n6_d2", q_data[2], 16'h1400);
      chk("n6_d3", q_data[3], 16'h1500);
      chk("n6_rc1", {q_row[1], q_col[1]}, {16'd0, 16'd1});
      chk("n6_rc2", {q_row[2], q_col[2]}, {16'd1, 16'd0});
      chk("n6_gap", q_cyc[1] - q_cyc[0], 26);
    end

    // saturation
    fill_block_const(16'h7FFF);
    fill_filt_const(16'h7FFF);
    run_pass(5, 100, 0, dc);
    chk("sat_pos_n", q_data.size(), 1);
    if (q_data.size() >= 1) chk("sat_pos", q_data[0], 16'h7FFF);
    fill_filt_const(16'h8000);
    run_pass(5, 100, 0, dc);
    chk("sat_neg_n", q_data.size(), 1);
`ifdef CONV_RELU_EN
    if (q_data.size() >= 1) chk("sat_neg", q_data[0], 16'h0000);
`else
    if (q_data.size() >= 1) chk("sat_neg", q_data[0], 16'h8000);
`endif

    // out-of-range sizes
    run_pass(4, 20, 0, dc);
    chk("n4_done_cyc", dc, 2);
    chk("n4_strobes", q_data.size(), 0);
    run_pass(33, 20, 0, dc);
    chk("n33_done_cyc", dc, 2);
    chk("n33_strobes", q_data.size(), 0);

    // held enable restarts straight after DONE
    run_pass(4, 20, 2, dc);
    chk("hold_done1", dc, 2);
    @(posedge clk); #1;
    chk("hold_c3_done", done, 0);
    chk("hold_c3_busy", busy, 1);
    @(posedge clk); #1;
    chk("hold_c4_done", done, 1);
    enable = 1'b0;
    watch_idle(4, nv, nd);

    // reset during pixel 2 of an N=8 pass
    fill_block_ramp();
    fill_filt_identity();
    @(negedge clk);
    size = 16'd8;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 2; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("rst_mid_pre", cnt, 2);
    chk("rst_mid_pre_data", out_data, 16'h1300);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_col", out_col, 0);
    watch_idle(60, nv, nd);
    chk("rst_mid_no_done", nd, 0);
    chk("rst_mid_no_valid", nv, 0);
    run_pass(8, 600, 0, dc);
    chk("n8_done_cyc", dc, 16 * 26 + 2);
    chk("n8_strobes", q_data.size(), 16);
    if (q_data.size() == 16) begin
      chk("n8_first", q_data[0], 16'h1200);
      chk("n8_rc4", {q_row[4], q_col[4]}, {16'd1, 16'd0});
      chk("n8_last", q_data[15], 16'h2D00);
      chk("n8_rc15", {q_row[15], q_col[15]}, {16'd3, 16'd3});
    end

    // enable toggled while busy on an N=7 pass
    run_pass(7, 400, 1, dc);
    chk("n7_done_cyc", dc, 9 * 26 + 2);
    chk("n7_strobes", q_data.size(), 9);
    if (q_data.size() == 9) chk("n7_last", q_data[8], 16'h2000);
    watch_idle(40, nv, nd);
    chk("n7_extra_done", nd, 0);
    chk("n7_extra_valid", nv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
